inst_queue: RTL and testbench

Fetch-to-decode instruction queue for the dynamic pipeline CPU. Buffers up to DEPTH fetched {pc, instruction} pairs between IF and ID, decouples fetch from decode stalls, and discards all contents on a redirect. Presents the head entry first-word-fall-through with its 16-bit immediate field and the signed/unsigned extension select already decoded, so the ID-stage 16→32 extender is driven straight from the queue head.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/inst_queue_if.sv | 29 ++
 rtl/imm_sign_decode.sv | 19 +
 rtl/inst_queue.sv | 75 +++++++
 tb/tb_inst_queue.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: MIPS opcode constants and the fetch-queue entry type.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  // Loads and stores occupy one contiguous opcode block.
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_SW     = 6'h2B;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        imm_sign;
  } iq_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-to-decode queue bus. Both sides use valid/ready: a beat transfers on
// any rising edge where valid and ready are both high; ready never depends on valid.
interface inst_queue_if #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) ();
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_pc;
  logic [31:0]      in_instr;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_pc;
  logic [31:0]      out_instr;
  logic [15:0]      out_imm16;
  logic             out_imm_sign;
  logic [PTR_W:0]   count;

  modport master (
    output in_valid, in_pc, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_imm16, out_imm_sign, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, flush, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_imm16, out_imm_sign, count
  );
endinterface

// File: rtl/imm_sign_decode.sv
// Opcode to immediate-extension select; shared with the ID-stage control decoder.
module imm_sign_decode
  import cpu_pkg::*;
(
  input  logic [5:0] opcode_i,
  output logic       imm_sign_o
);
  // Branches and arithmetic immediates form one run (beq..sltiu); logical ops and lui zero-extend.
  always_comb begin
    imm_sign_o = 1'b0;
    if (opcode_i == OP_REGIMM) begin
      imm_sign_o = 1'b1;
    end else if (opcode_i >= OP_BEQ && opcode_i <= OP_SLTIU) begin
      imm_sign_o = 1'b1;
    end else if (opcode_i >= OP_LB && opcode_i <= OP_SW) begin
      imm_sign_o = 1'b1;
    end
  end
endmodule

// File: rtl/inst_queue.sv
// IF->ID instruction queue: FWFT head with predecoded immediate, flushed on redirect.
module inst_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rstn,
  inst_queue_if.slave  q
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  iq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full, empty, push, pop, wr_sign;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign push  = q.in_valid && !full;
  assign pop   = q.out_ready && !empty;

  imm_sign_decode u_imm_sign_decode (
    .opcode_i   (q.in_instr[31:26]),
    .imm_sign_o (wr_sign)
  );

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; count alone decides what is live.
  always_ff @(posedge clk) begin
    if (rstn && push && !q.flush) begin
      mem_q[wr_ptr_q] <= '{pc: q.in_pc, instr: q.in_instr, imm_sign: wr_sign};
    end
  end

  assign q.in_ready     = !full;
  assign q.out_valid    = !empty;
  assign q.out_pc       = mem_q[rd_ptr_q].pc;
  assign q.out_instr    = mem_q[rd_ptr_q].instr;
  assign q.out_imm16    = mem_q[rd_ptr_q].instr[15:0];
  assign q.out_imm_sign = mem_q[rd_ptr_q].imm_sign;
  assign q.count        = count_q;
endmodule

// File: tb/tb_inst_queue.sv
// Directed + random bench for inst_queue with a scoreboard of {pc, instr, imm_sign}.
module tb_inst_queue;
  localparam int DEPTH = 4;
  localparam int W     = 65;

  logic clk;
  logic rstn;
  int   total = 0;
  int   bad   = 0;
  bit   checking = 1'b0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  pc;

  inst_queue_if #(.DEPTH(DEPTH)) bus ();

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .q    (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model helpers ----------------
  function automatic logic exp_sign(input logic [5:0] op);
    case (op)
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h28, 6'h29, 6'h2A, 6'h2B: exp_sign = 1'b1;
      default:                    exp_sign = 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [W-1:0] e;
    chk("count", 32'(bus.count), 32'(exp_q.size()));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(exp_q.size() < DEPTH));
    if (exp_q.size() > 0) begin
      e = exp_q[0];
      chk("head_pc", bus.out_pc, e[64:33]);
      chk("head_instr", bus.out_instr, e[32:1]);
      chk("head_imm16", 32'(bus.out_imm16), 32'(e[16:1]));
      chk("head_sign", 32'(bus.out_imm_sign), 32'(e[0]));
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic v, input logic [31:0] p, input logic [31:0] ins,
                       input logic rdy, input logic fl, input logic rn);
    bus.in_valid  = v;
    bus.in_pc     = p;
    bus.in_instr  = ins;
    bus.out_ready = rdy;
    bus.flush     = fl;
    rstn          = rn;
    if (checking) check_outputs();
    if (!rn || fl) begin
      exp_q.delete();
    end else begin
      logic do_pop, do_push;
      do_pop  = rdy && (exp_q.size() > 0);
      do_push = v && (exp_q.size() < DEPTH);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({p, ins, exp_sign(ins[31:26])});
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h01, 6'h03, 6'h08, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    rand_instr = {ops[$urandom_range(0, 7)], 26'($urandom)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] fill_ins [4];
    logic        fill_sgn [4];
    fill_ins = '{32'h3108FFFF, 32'h3C01ABCD, 32'h8C220004, 32'h00851020};
    fill_sgn = '{1'b0, 1'b0, 1'b1, 1'b0};
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0;
    bus.out_ready = 1'b0; bus.flush = 1'b0; rstn = 1'b0;

    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    checking = 1'b1;

    // reset state and first push (addi)
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    cycle(1, 32'h00400000, 32'h2108FFFF, 0, 0, 1);
    chk("addi_imm16", 32'(bus.out_imm16), 32'hFFFF);
    chk("addi_sign", 32'(bus.out_imm_sign), 1);
    chk("addi_count", 32'(bus.count), 1);
    cycle(0, 0, 0, 1, 0, 1);

    // fill to full, fifth push ignored, drain in order
    for (int i = 0; i < 4; i++) cycle(1, 32'h00400004 + 32'(i * 4), fill_ins[i], 0, 0, 1);
    chk("full_count", 32'(bus.count), 4);
    chk("full_in_ready", 32'(bus.in_ready), 0);
    cycle(1, 32'h00400014, 32'h20000001, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      chk("drain_sign", 32'(bus.out_imm_sign), 32'(fill_sgn[i]));
      chk("drain_pc", bus.out_pc, 32'h00400004 + 32'(i * 4));
      cycle(0, 0, 0, 1, 0, 1);
    end

    // full with push and pop: pop only
    pc = 32'h00001000;
    for (int i = 0; i < 4; i++) begin cycle(1, pc, rand_instr(), 0, 0, 1); pc += 4; end
    cycle(1, pc, rand_instr(), 1, 0, 1); pc += 4;
    chk("fullpp_count", 32'(bus.count), 3);
    chk("fullpp_in_ready", 32'(bus.in_ready), 1);

    // count=2 sustained push+pop across pointer wrap
    cycle(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) begin cycle(1, pc, rand_instr(), 1, 0, 1); pc += 4; end
    chk("stream_count", 32'(bus.count), 2);

    // flush beats simultaneous push and pop
    cycle(1, pc, rand_instr(), 0, 0, 1); pc += 4;
    cycle(1, pc, rand_instr(), 1, 1, 1); pc += 4;
    chk("flush_count", 32'(bus.count), 0);
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    cycle(1, 32'h00ABC000, 32'h24420001, 0, 0, 1);
    chk("post_flush_pc", bus.out_pc, 32'h00ABC000);

    // reset mid-stream with a push pending
    cycle(1, pc, rand_instr(), 0, 0, 1); pc += 4;
    cycle(1, pc, rand_instr(), 0, 0, 1); pc += 4;
    cycle(1, pc, rand_instr(), 0, 0, 0); pc += 4;
    chk("midrst_count", 32'(bus.count), 0);
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_in_ready", 32'(bus.in_ready), 1);

    // random traffic with occasional flush
    for (int i = 0; i < 60; i++) begin
      cycle(1'($urandom_range(0, 1)), pc, rand_instr(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) == 0), 1);
      pc += 4;
    end
    check_outputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
